// File: rtl/seq_mult16.sv
// Unsigned 16x16->32 shift-and-add multiplier, one multiplier bit per clock,
// with a 16-bit carry-lookahead adder forming each partial sum.

module cla_add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g     = x & y;
  assign p     = x ^ y;
  assign gc[0] = cin;

  // Group generate/propagate across 4-bit groups; bit carries ripple only inside a group.
  for (genvar gi = 0; gi < 4; gi++) begin : g_group
    assign gp[gi] = &p[4*gi +: 4];
    assign gg[gi] = g[4*gi+3]
                  | (p[4*gi+3] & g[4*gi+2])
                  | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                  | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
    assign gc[gi+1] = gg[gi] | (gp[gi] & gc[gi]);
    assign c[4*gi]  = gc[gi];
    for (genvar bj = 0; bj < 3; bj++) begin : g_bit
      assign c[4*gi+bj+1] = g[4*gi+bj] | (p[4*gi+bj] & c[4*gi+bj]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

module seq_mult16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] product
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_reg;
  logic [15:0] m_reg;
  logic [15:0] acc_reg;
  logic [15:0] q_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] product_reg;
  logic        ready_reg;
  logic        done_reg;

  logic [15:0] addend;
  logic [15:0] sum;
  logic        cout;
  logic [31:0] shifted;

  assign addend = q_reg[0] ? m_reg : 16'h0000;

  cla_add16 u_add (
    .x    (acc_reg),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // 33-bit right shift of {cout, sum, Q}; the carry must land in A[15].
  assign shifted = {cout, sum, q_reg[15:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      m_reg       <= 16'h0000;
      acc_reg     <= 16'h0000;
      q_reg       <= 16'h0000;
      cnt_reg     <= 5'd0;
      product_reg <= 32'h0000_0000;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            m_reg     <= a;
            q_reg     <= b;
            acc_reg   <= 16'h0000;
            cnt_reg   <= 5'd0;
            ready_reg <= 1'b0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_reg <= shifted[31:16];
          q_reg   <= shifted[15:0];
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd15) begin
            product_reg <= shifted;
            done_reg    <= 1'b1;
            state_reg   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready   = ready_reg;
  assign done    = done_reg;
  assign product = product_reg;
endmodule

// File: tb/tb_seq_mult16.sv
// Scoreboard bench for seq_mult16: a cycle-level reference model queues
// expected products and done cycles; a monitor checks every cycle.

module tb_seq_mult16;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        ready;
  logic        done;
  logic [31:0] product;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          free_at = 0;
  bit          armed = 1'b0;
  logic [31:0] held = 32'h0;
  int          checks = 0;
  int          errors = 0;

  seq_mult16 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted request yields a*b 16 edges later; the block is busy for 18 edges.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        free_at = cyc + 1;
        held    = 32'h0;
        armed   = 1'b1;
      end else if (start && armed && cyc >= free_at) begin
        exp_t e;
        e.prod  = 32'(a) * 32'(b);
        e.cyc   = cyc + 16;
        free_at = cyc + 18;
        exp_q.push_back(e);
        $display("cyc %0d: accept a=%h b=%h expect %h at cyc %0d", cyc, a, b, e.prod, e.cyc);
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        logic exp_ready;
        logic exp_done;
        exp_ready = (cyc >= free_at - 1);
        exp_done  = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        checks++;
        if (ready !== exp_ready) begin
          errors++;
          $display("FAIL ready cyc %0d: got %b want %b", cyc, ready, exp_ready);
        end
        checks++;
        if (done !== exp_done) begin
          errors++;
          $display("FAIL done cyc %0d: got %b want %b", cyc, done, exp_done);
        end
        if (done === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL product cyc %0d: got %h want no result pending", cyc, product);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (product !== e.prod) begin
              errors++;
              $display("FAIL product cyc %0d: got %h want %h", cyc, product, e.prod);
            end else begin
              $display("cyc %0d: done product=%h ok", cyc, product);
            end
            held = e.prod;
          end
        end else begin
          checks++;
          if (product !== held) begin
            errors++;
            $display("FAIL hold cyc %0d: got %h want %h", cyc, product, held);
          end
        end
      end
    end
  end

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] dir_a[5] = '{16'h0003, 16'hFFFF, 16'h8000, 16'h0000, 16'h1234};
    logic [15:0] dir_b[5] = '{16'h0005, 16'hFFFF, 16'h0002, 16'h1234, 16'h0001};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) do_op(dir_a[i], dir_b[i]);

    // Start requests while busy (RUN and DONE) must be ignored.
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 16'd2; b = 16'd2;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a run discards it.
    a = 16'h00FF; b = 16'h0100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    do_op(16'h0010, 16'h0010);

    // Continuous start: one accept every 18 cycles.
    a = 16'h0002; b = 16'h0003; start = 1'b1;
    repeat (56) @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      do_op(16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
